// File: rtl/mips_multicycle.sv
// Multicycle MIPS-subset core with one shared memory port.
// Optional bne support is enabled by defining MIPS_MC_BNE_EN.
module mips_multicycle #(
    parameter int          ADDR_W   = 32,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic              clk,
    input  logic              resetN,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              halted,
    output logic [31:0]       retired
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
`ifdef MIPS_MC_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'h05;
`endif
    localparam logic [5:0] F_ADD    = 6'h20;
    localparam logic [5:0] F_SUB    = 6'h22;
    localparam logic [5:0] F_AND    = 6'h24;
    localparam logic [5:0] F_OR     = 6'h25;
    localparam logic [5:0] F_SLT    = 6'h2A;

    typedef enum logic [2:0] {
        FETCH, DECODE, EXEC, MEM, WB, HALT
    } state_t;

    state_t             r_state;
    logic [ADDR_W-1:0]  r_pc;
    logic [31:0]        r_ir;
    logic [31:0]        r_a;
    logic [31:0]        r_b;
    logic [31:0]        r_imm;
    logic [31:0]        r_alu;
    logic [31:0]        r_rf [32];
    logic               r_mem_req;
    logic               r_mem_we;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [31:0]        r_mem_wdata;
    logic               r_halted;
    logic [31:0]        r_retired;

    logic [5:0]         w_op;
    logic [4:0]         w_rs;
    logic [4:0]         w_rt;
    logic [4:0]         w_rd;
    logic [4:0]         w_shamt;
    logic [5:0]         w_funct;
    logic [4:0]         w_dest;
    logic               w_legal;
    logic               w_is_ctrl;
    logic               w_is_mem;
    logic               w_is_sw;
    logic               w_taken;
    logic [31:0]        w_alu;
    logic [31:0]        w_pc32;
    logic [31:0]        w_br;
    logic [31:0]        w_jmp;
    logic [ADDR_W-1:0]  w_next_pc;

    assign w_op      = r_ir[31:26];
    assign w_rs      = r_ir[25:21];
    assign w_rt      = r_ir[20:16];
    assign w_rd      = r_ir[15:11];
    assign w_shamt   = r_ir[10:6];
    assign w_funct   = r_ir[5:0];
    assign w_dest    = (w_op == OP_RTYPE) ? w_rd : w_rt;
    assign w_is_sw   = (w_op == OP_SW);
    assign w_is_mem  = (w_op == OP_LW) || w_is_sw;
    assign w_pc32    = 32'(r_pc);
    assign w_br      = w_pc32 + (r_imm << 2);
    assign w_jmp     = {w_pc32[31:28], r_ir[25:0], 2'b00};

    // Opcode/funct legality check used by DECODE
    always_comb begin
        w_legal = 1'b0;
        case (w_op)
            OP_RTYPE: w_legal = (w_shamt == 5'd0) &&
                                ((w_funct == F_ADD) || (w_funct == F_SUB) ||
                                 (w_funct == F_AND) || (w_funct == F_OR)  ||
                                 (w_funct == F_SLT));
            OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: w_legal = 1'b1;
`ifdef MIPS_MC_BNE_EN
            OP_BNE:   w_legal = 1'b1;
`endif
            default:  w_legal = 1'b0;
        endcase
    end

    // ALU: immediate add for addi/lw/sw, funct-selected op for R-type
    always_comb begin
        w_alu = r_a + r_imm;
        if (w_op == OP_RTYPE) begin
            case (w_funct)
                F_SUB:   w_alu = r_a - r_b;
                F_AND:   w_alu = r_a & r_b;
                F_OR:    w_alu = r_a | r_b;
                F_SLT:   w_alu = {31'd0, ($signed(r_a) < $signed(r_b))};
                default: w_alu = r_a + r_b;
            endcase
        end
    end

    // Branch/jump resolution; r_pc already points past the instruction
    always_comb begin
        w_is_ctrl = (w_op == OP_J) || (w_op == OP_BEQ);
        w_taken   = (w_op == OP_BEQ) && (r_a == r_b);
`ifdef MIPS_MC_BNE_EN
        w_is_ctrl = w_is_ctrl || (w_op == OP_BNE);
        w_taken   = w_taken || ((w_op == OP_BNE) && (r_a != r_b));
`endif
        if (w_op == OP_J)
            w_next_pc = w_jmp[ADDR_W-1:0];
        else if (w_taken)
            w_next_pc = w_br[ADDR_W-1:0];
        else
            w_next_pc = r_pc;
    end

    // Main control FSM, datapath registers and register file
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state     <= FETCH;
            r_pc        <= RESET_PC[ADDR_W-1:0];
            r_ir        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_imm       <= '0;
            r_alu       <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_halted    <= 1'b0;
            r_retired   <= '0;
            for (int i = 0; i < 32; i++) r_rf[i] <= '0;
        end else begin
            unique case (r_state)
                FETCH: begin
                    if (!r_mem_req) begin
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= {r_pc[ADDR_W-1:2], 2'b00};
                    end else if (mem_ready) begin
                        r_ir      <= mem_rdata;
                        r_pc      <= r_pc + ADDR_W'(4);
                        r_mem_req <= 1'b0;
                        r_state   <= DECODE;
                    end
                end
                DECODE: begin
                    r_a   <= r_rf[w_rs];
                    r_b   <= r_rf[w_rt];
                    r_imm <= {{16{r_ir[15]}}, r_ir[15:0]};
                    if (w_legal) begin
                        r_state <= EXEC;
                    end else begin
                        r_halted <= 1'b1;
                        r_state  <= HALT;
                    end
                end
                EXEC: begin
                    if (w_is_ctrl) begin
                        r_pc       <= w_next_pc;
                        r_retired  <= r_retired + 32'd1;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= {w_next_pc[ADDR_W-1:2], 2'b00};
                        r_state    <= FETCH;
                    end else if (w_is_mem) begin
                        r_alu       <= w_alu;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= w_is_sw;
                        r_mem_addr  <= {w_alu[ADDR_W-1:2], 2'b00};
                        r_mem_wdata <= w_is_sw ? r_b : 32'd0;
                        r_state     <= MEM;
                    end else begin
                        r_alu   <= w_alu;
                        r_state <= WB;
                    end
                end
                MEM: begin
                    if (mem_ready) begin
                        r_mem_we    <= 1'b0;
                        r_mem_wdata <= '0;
                        if (r_mem_we) begin
                            r_retired  <= r_retired + 32'd1;
                            r_mem_addr <= {r_pc[ADDR_W-1:2], 2'b00};
                            r_state    <= FETCH;
                        end else begin
                            r_alu     <= mem_rdata;
                            r_mem_req <= 1'b0;
                            r_state   <= WB;
                        end
                    end
                end
                WB: begin
                    if (w_dest != 5'd0) r_rf[w_dest] <= r_alu;
                    r_retired  <= r_retired + 32'd1;
                    r_mem_req  <= 1'b1;
                    r_mem_addr <= {r_pc[ADDR_W-1:2], 2'b00};
                    r_state    <= FETCH;
                end
                HALT: begin
                    r_mem_req <= 1'b0;
                end
                default: begin
                    r_halted <= 1'b1;
                    r_state  <= HALT;
                end
            endcase
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign halted    = r_halted;
    assign retired   = r_retired;

endmodule
